// File: rtl/sha256_stream_engine.sv
// SHA-256 stream engine: reads a word-aligned message of runtime length,
// pads and hashes it (optionally twice) and writes the digest back.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start, num_words,       launch request and job parameters,
//   double_hash,            all latched when start is accepted in IDLE
//   message_addr, output_addr
//   busy, done, error       job status (done/error are one-cycle pulses)
//   mem_clk, mem_we,        shared word-addressed memory port; read data
//   mem_addr, mem_write_data, mem_read_data  is valid one cycle after addr
module sha256_stream_engine #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       num_words,
    input  logic              double_hash,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE, CHECK, READ, PAD, COMPUTE, UPDATE, PAD2, WRITE
    } state_t;

    state_t state, state_d;

    logic [15:0]       len;
    logic              dbl;
    logic              second;
    logic [ADDR_W-1:0] msg_base;
    logic [ADDR_W-1:0] out_base;
    logic [12:0]       blk;
    logic [3:0]        rd_j;
    logic [3:0]        rd_idx;
    logic              rd_pend;
    logic [5:0]        rnd;
    logic [2:0]        wk;
    logic [31:0]       h [8];
    logic [31:0]       v [8];
    logic [31:0]       w [16];
    logic [31:0]       pad_w [16];
    logic              done_d;
    logic              err_d;

    logic [16:0] base;
    logic [16:0] nblk;
    logic [16:0] tot;
    logic [16:0] left;
    logic [16:0] g;
    logic [3:0]  last_j;
    logic        last_blk;
    logic        more_next;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign mem_clk = clk;
    assign busy    = (state != IDLE);

    // Block geometry: base is the global index of word 0 of this block,
    // tot is 16N, the padded message length in words.
    always_comb begin
        base      = {blk, 4'b0};
        nblk      = ({1'b0, len} + 17'd18) >> 4;
        tot       = {nblk[12:0], 4'b0};
        left      = {1'b0, len} - base;
        last_j    = (left >= 17'd16) ? 4'd15 : left[3:0] - 4'd1;
        last_blk  = ({4'b0, blk} + 17'd1) == nblk;
        more_next = {1'b0, len} > (base + 17'd16);
    end

    // Message words already captured stay; everything past L is padding.
    always_comb begin
        g = '0;
        for (int j = 0; j < 16; j++) begin
            g = base + 17'(j);
            if (g < {1'b0, len})
                pad_w[j] = w[j];
            else if (g == {1'b0, len})
                pad_w[j] = 32'h80000000;
            else if (g == tot - 17'd2)
                pad_w[j] = {27'b0, len[15:11]};
            else if (g == tot - 17'd1)
                pad_w[j] = {len[10:0], 5'b0};
            else
                pad_w[j] = '0;
        end
    end

    // One round; w[0] is W_t and the window slides by one per round.
    always_comb begin
        t1 = v[7] + big_s1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + K[rnd] + w[0];
        t2 = big_s0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_new = sml_s1(w[14]) + w[9] + sml_s0(w[1]) + w[0];
    end

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_d = CHECK;
            end
            CHECK: begin
                if ({1'b0, len} > MAX_L) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = (len != 16'd0) ? READ : PAD;
                end
            end
            READ: begin
                if (rd_j == last_j)
                    state_d = PAD;
            end
            PAD: state_d = COMPUTE;
            COMPUTE: begin
                if (rnd == 6'd63)
                    state_d = UPDATE;
            end
            UPDATE: begin
                if (!last_blk)
                    state_d = more_next ? READ : PAD;
                else if (dbl && !second)
                    state_d = PAD2;
                else
                    state_d = WRITE;
            end
            PAD2: state_d = COMPUTE;
            WRITE: begin
                if (wk == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
            error <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_pend <= (state == READ);
        rd_idx  <= rd_j;
        unique case (state)
            IDLE: begin
                if (start) begin
                    len      <= num_words;
                    dbl      <= double_hash;
                    msg_base <= message_addr;
                    out_base <= output_addr;
                    second   <= 1'b0;
                end
            end
            CHECK: begin
                for (int i = 0; i < 8; i++)
                    h[i] <= IV[i];
                blk  <= '0;
                rd_j <= '0;
                wk   <= '0;
            end
            READ: rd_j <= rd_j + 4'd1;
            PAD: begin
                for (int j = 0; j < 16; j++)
                    w[j] <= pad_w[j];
                for (int i = 0; i < 8; i++)
                    v[i] <= h[i];
                rnd <= '0;
            end
            COMPUTE: begin
                v[0] <= t1 + t2;
                v[1] <= v[0];
                v[2] <= v[1];
                v[3] <= v[2];
                v[4] <= v[3] + t1;
                v[5] <= v[4];
                v[6] <= v[5];
                v[7] <= v[6];
                for (int j = 0; j < 15; j++)
                    w[j] <= w[j+1];
                w[15] <= w_new;
                rnd   <= rnd + 6'd1;
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++)
                    h[i] <= h[i] + v[i];
                if (!last_blk)
                    blk <= blk + 13'd1;
                rd_j <= '0;
                wk   <= '0;
            end
            PAD2: begin
                // Second pass hashes the 256-bit first digest.
                for (int i = 0; i < 8; i++) begin
                    w[i] <= h[i];
                    h[i] <= IV[i];
                    v[i] <= IV[i];
                end
                w[8] <= 32'h80000000;
                for (int j = 9; j < 15; j++)
                    w[j] <= '0;
                w[15]  <= 32'h00000100;
                second <= 1'b1;
                rnd    <= '0;
            end
            WRITE: wk <= wk + 3'd1;
            default: ;
        endcase
        // The last read of a block lands during PAD, after the pad load.
        if (rd_pend)
            w[rd_idx] <= mem_read_data;
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (state == READ) begin
            mem_addr = msg_base + ADDR_W'(base) + ADDR_W'(rd_j);
        end else if (state == WRITE) begin
            mem_we         = 1'b1;
            mem_addr       = out_base + ADDR_W'(wk);
            mem_write_data = h[wk];
        end
    end

endmodule

// File: tb/tb_sha256_stream_engine.sv
// Randomized bench for sha256_stream_engine against a plain SHA-256 model.
// Holds a 64K-word memory model on the engine's memory port.
module tb_sha256_stream_engine;

    localparam int MAXW = 256;

    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic        double_hash = 1'b0;
    logic [15:0] message_addr = '0;
    logic [15:0] output_addr = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  mem [0:65535];
    logic         ld_en = 1'b0;
    logic [15:0]  ld_addr = '0;
    logic [31:0]  ld_data = '0;

    int           exp_busy;
    int           exp_reads;
    bit           exp_err;
    logic [255:0] exp_dig;
    logic [15:0]  cur_oa;
    logic [255:0] last_got;

    sha256_stream_engine #(.MAX_WORDS(MAXW), .ADDR_W(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .num_words(num_words),
        .double_hash(double_hash),
        .message_addr(message_addr),
        .output_addr(output_addr),
        .busy(busy),
        .done(done),
        .error(error),
        .mem_clk(mem_clk),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_we)
            mem[mem_addr] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_q(input logic [31:0] m [$]);
        logic [31:0] p [$];
        logic [31:0] hv [8];
        logic [31:0] ww [64];
        logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
        logic [63:0] bits;
        p = m;
        bits = 64'(m.size()) * 64'd32;
        p.push_back(32'h80000000);
        while (p.size() % 16 != 14)
            p.push_back(32'h0);
        p.push_back(bits[63:32]);
        p.push_back(bits[31:0]);
        hv = IVT;
        for (int k = 0; k < p.size() / 16; k++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16)
                    ww[t] = p[16*k+t];
                else
                    ww[t] = (rr(ww[t-2], 17) ^ rr(ww[t-2], 19) ^ (ww[t-2] >> 10))
                          + ww[t-7]
                          + (rr(ww[t-15], 7) ^ rr(ww[t-15], 18) ^ (ww[t-15] >> 3))
                          + ww[t-16];
            end
            a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
            e = hv[4]; f = hv[5]; g = hv[6]; hh = hv[7];
            for (int t = 0; t < 64; t++) begin
                x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25))
                   + ((e & f) ^ (~e & g)) + KT[t] + ww[t];
                x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22))
                   + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + x1;
                d = c; c = b; b = a; a = x1 + x2;
            end
            hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
            hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += hh;
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    function automatic logic [255:0] read_out(input logic [15:0] oa);
        logic [255:0] r;
        logic [15:0]  ad;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            ad = oa + 16'(k);
            r[255-32*k -: 32] = mem[ad];
        end
        return r;
    endfunction

    task automatic launch(input int L, input bit dbl, input logic [15:0] ma,
                          input logic [15:0] oa, input bit abcd);
        logic [31:0]  q [$];
        logic [31:0]  dq [$];
        logic [255:0] d;
        logic [15:0]  ad;
        logic [31:0]  wv;
        int           nb;
        q = {};
        exp_err = (L > MAXW);
        if (!exp_err) begin
            for (int i = 0; i < L; i++) begin
                wv = (abcd && i == 0) ? 32'h61626364 : $urandom;
                q.push_back(wv);
                poke(ma + 16'(i), wv);
            end
        end
        for (int k = 0; k < 8; k++)
            poke(oa + 16'(k), 32'hDEADBEEF);
        if (exp_err) begin
            exp_busy  = 1;
            exp_reads = 0;
            exp_dig   = {8{32'hDEADBEEF}};
        end else begin
            d = sha_q(q);
            if (dbl) begin
                dq = {};
                for (int k = 0; k < 8; k++)
                    dq.push_back(d[255-32*k -: 32]);
                d = sha_q(dq);
            end
            exp_dig = d;
            nb = (L + 3 + 15) / 16;
            exp_busy = 1 + L + nb * 66 + (dbl ? 66 : 0) + 8;
            exp_reads = 0;
            for (int i = 0; i < L; i++) begin
                ad = ma + 16'(i);
                if (ad != 16'h0)
                    exp_reads++;
            end
        end
        num_words    = 16'(L);
        double_hash  = dbl;
        message_addr = ma;
        output_addr  = oa;
        cur_oa       = oa;
        start        = 1'b1;
    endtask

    task automatic wait_job(input string tag, input int poke_at);
        int bc, rc, wc, ec, done_at;
        bit seen;
        bc = 0; rc = 0; wc = 0; ec = 0; done_at = 0; seen = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (c == 1)
                start = 1'b0;
            if (c == poke_at) begin
                start        = 1'b1;
                num_words    = 16'd3;
                double_hash  = 1'b0;
                message_addr = 16'h0040;
                output_addr  = 16'h0050;
            end
            if (c == poke_at + 1)
                start = 1'b0;
            if (busy) bc++;
            if (busy && !mem_we && mem_addr != 16'h0) rc++;
            if (mem_we) wc++;
            if (error) ec++;
            if (done) begin
                seen    = 1;
                done_at = c;
                check({tag, ":busy_at_done"}, 256'(busy), 256'(0));
                break;
            end
        end
        check({tag, ":done_seen"}, 256'(seen), 256'(1));
        check({tag, ":busy_cycles"}, 256'(bc), 256'(exp_busy));
        check({tag, ":done_latency"}, 256'(done_at), 256'(exp_busy + 1));
        check({tag, ":reads"}, 256'(rc), 256'(exp_reads));
        check({tag, ":writes"}, 256'(wc), 256'(exp_err ? 0 : 8));
        check({tag, ":error"}, 256'(ec), 256'(exp_err ? 1 : 0));
        @(negedge clk);
        check({tag, ":done_once"}, 256'({done, error}), 256'(0));
        last_got = read_out(cur_oa);
        check({tag, ":digest"}, last_got, exp_dig);
    endtask

    initial begin
        int bc, wc;
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done_err", 256'({done, error}), 256'(0));
        check("rst_we", 256'(mem_we), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_wdata", 256'(mem_write_data), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        launch(0, 0, 16'h1000, 16'h9000, 0);
        wait_job("empty", 0);
        check("empty_golden", last_got,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        launch(1, 0, 16'h1100, 16'h9100, 1);
        wait_job("abcd", 0);
        check("abcd_golden", last_got,
              256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);

        launch(0, 1, 16'h1200, 16'h9200, 0);
        wait_job("empty_dbl", 0);
        check("empty_dbl_golden", last_got,
              256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456);

        launch(13, 0, 16'h2000, 16'h9300, 0);
        wait_job("l13", 0);
        launch(14, 0, 16'h2100, 16'h9400, 0);
        wait_job("l14", 0);
        launch(16, 1, 16'h2200, 16'h9500, 0);
        wait_job("l16_dbl", 0);
        launch(29, 0, 16'h2300, 16'h9600, 0);
        wait_job("l29", 0);
        launch(30, 1, 16'h2400, 16'h9700, 0);
        wait_job("l30_dbl", 0);

        launch(MAXW + 1, 0, 16'h2500, 16'h9800, 0);
        wait_job("over", 0);
        launch(65535, 1, 16'h2600, 16'h9900, 0);
        wait_job("over_max", 0);
        launch(MAXW, 0, 16'h3000, 16'h9A00, 0);
        wait_job("max", 0);

        launch(20, 0, 16'hFFF8, 16'h9B00, 0);
        wait_job("wrap", 0);

        launch(10, 0, 16'h0100, 16'h9C00, 0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)
                start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_we", 256'(mem_we), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        reset_n = 1'b1;
        bc = 0;
        wc = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (mem_we) wc++;
        end
        check("midrst_idle", 256'(bc), 256'(0));
        check("midrst_nowrite", 256'(wc), 256'(0));
        check("midrst_mem", read_out(16'h9C00), {8{32'hDEADBEEF}});

        launch(20, 1, 16'h1300, 16'hA000, 0);
        wait_job("ignore_start", 10);
        launch(20, 0, 16'h1400, 16'hA100, 0);
        wait_job("fresh", 0);

        for (int r = 0; r < 6; r++) begin
            launch(int'($urandom_range(0, 48)), 1'($urandom_range(0, 1)),
                   16'h4000 + 16'($urandom_range(0, 16'h3000)),
                   16'hB000 + 16'($urandom_range(0, 16'h3000)), 0);
            wait_job($sformatf("rand%0d", r), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
